// File: rtl/serial_twos_decoder.sv
// serial_twos_decoder
//   Bit-serial two's-complement to sign-magnitude decoder. One WIDTH-bit
//   word is accepted on an input valid/ready handshake. It is walked LSB-first,
//   one bit per clock, using the copy-until-first-1-then-invert rule. Sign and
//   magnitude are then presented on an output valid/ready handshake.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for a word; in_ready high (from the first edge after reset)
//   SHIFT | walking the captured word, one bit per edge, WIDTH edges total
//   DONE  | result held on out_sign/out_mag with out_valid high until out_ready
//
// Ports
//   clk        system clock, all state on rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   in_data holds a word to decode
//   in_ready   decoder can accept a word this cycle (registered)
//   in_data    two's-complement input word
//   out_valid  out_sign/out_mag hold a finished result
//   out_ready  consumer takes the result this cycle
//   out_sign   1 = negative input
//   out_mag    unsigned magnitude of in_data
//   busy       high in SHIFT or DONE
module serial_twos_decoder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [WIDTH-1:0] out_mag,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [WIDTH-1:0] mag, mag_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             sign, sign_nxt;
  logic             seen1, seen1_nxt;
  logic             in_ready_nxt;
  logic             out_valid_nxt;
  logic             out_sign_nxt;
  logic [WIDTH-1:0] out_mag_nxt;
  logic             busy_nxt;
  logic             bit_o;

  // Negative words invert every bit above the lowest set bit; the lowest set
  // bit itself and the zeros below it pass through unchanged.
  assign bit_o = (sign & seen1) ? ~shreg[0] : shreg[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shreg     <= '0;
      mag       <= '0;
      cnt       <= '0;
      sign      <= 1'b0;
      seen1     <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_sign  <= 1'b0;
      out_mag   <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      shreg     <= shreg_nxt;
      mag       <= mag_nxt;
      cnt       <= cnt_nxt;
      sign      <= sign_nxt;
      seen1     <= seen1_nxt;
      in_ready  <= in_ready_nxt;
      out_valid <= out_valid_nxt;
      out_sign  <= out_sign_nxt;
      out_mag   <= out_mag_nxt;
      busy      <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    shreg_nxt     = shreg;
    mag_nxt       = mag;
    cnt_nxt       = cnt;
    sign_nxt      = sign;
    seen1_nxt     = seen1;
    in_ready_nxt  = in_ready;
    out_valid_nxt = out_valid;
    out_sign_nxt  = out_sign;
    out_mag_nxt   = out_mag;
    busy_nxt      = busy;

    case (state)
      IDLE: begin
        // in_ready is low for the first edge after reset, so gate on it to
        // keep acceptance consistent with what the producer saw.
        in_ready_nxt = 1'b1;
        if (in_valid && in_ready) begin
          shreg_nxt    = in_data;
          sign_nxt     = in_data[WIDTH-1];
          cnt_nxt      = '0;
          seen1_nxt    = 1'b0;
          in_ready_nxt = 1'b0;
          busy_nxt     = 1'b1;
          state_nxt    = SHIFT;
        end
      end
      SHIFT: begin
        seen1_nxt = seen1 | shreg[0];
        mag_nxt   = {bit_o, mag[WIDTH-1:1]};
        shreg_nxt = {1'b0, shreg[WIDTH-1:1]};
        cnt_nxt   = cnt + CNT_W'(1);
        if (cnt == CNT_LAST) begin
          state_nxt     = DONE;
          out_valid_nxt = 1'b1;
          out_sign_nxt  = sign;
          out_mag_nxt   = mag_nxt;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_nxt = 1'b0;
          busy_nxt      = 1'b0;
          in_ready_nxt  = 1'b1;
          state_nxt     = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_twos_decoder.sv
module tb_serial_twos_decoder;

  localparam int WIDTH = 8;
  localparam int NRAND = 1000;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_sign;
  logic [WIDTH-1:0] out_mag;
  logic             busy;

  int checks = 0;
  int errors = 0;

  serial_twos_decoder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_mag   (out_mag),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       sign;
    logic [7:0] mag;
    int         hold;
    logic       early;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Full transaction with latency and hold checks. Caller sits just after a negedge.
  task automatic run_word(input logic [7:0] d, input logic es, input logic [7:0] em,
                          input int hold, input logic early);
    int lat;
    int w;
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    in_valid  = 1'b1;
    in_data   = d;
    out_ready = early;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = ~d;
    lat = 0;
    @(negedge clk);
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk("latency", lat, 32'd8);
    chk("sign", {31'd0, out_sign}, {31'd0, es});
    chk("mag", {24'd0, out_mag}, {24'd0, em});
    chk("in_ready_in_done", {31'd0, in_ready}, 32'd0);
    if (!early) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("hold_valid", {31'd0, out_valid}, 32'd1);
        chk("hold_mag", {23'd0, out_sign, out_mag}, {23'd0, es, em});
        chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("valid_after_handoff", {31'd0, out_valid}, 32'd0);
    chk("in_ready_after_handoff", {31'd0, in_ready}, 32'd1);
    chk("mag_kept", {23'd0, out_sign, out_mag}, {23'd0, es, em});
  endtask

  logic [7:0] expq[$];

  function automatic logic [8:0] model(input logic [7:0] x);
    logic [7:0] m;
    m = x[7] ? 8'(8'd0 - x) : x;
    return {x[7], m};
  endfunction

  initial begin
    vecs[0] = '{8'h05, 1'b0, 8'h05, 0, 1'b0};
    vecs[1] = '{8'h00, 1'b0, 8'h00, 0, 1'b0};
    vecs[2] = '{8'hFB, 1'b1, 8'h05, 2, 1'b0};
    vecs[3] = '{8'hFF, 1'b1, 8'h01, 0, 1'b0};
    vecs[4] = '{8'h80, 1'b1, 8'h80, 5, 1'b0};
    vecs[5] = '{8'h7F, 1'b0, 8'h7F, 0, 1'b1};
    vecs[6] = '{8'h01, 1'b0, 8'h01, 0, 1'b1};
    vecs[7] = '{8'h9C, 1'b1, 8'h64, 1, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #1;
    chk("rst_outputs", {20'd0, in_ready, out_valid, out_sign, busy, out_mag},
        32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("in_ready_pre_edge", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    chk("in_ready_post_edge", {31'd0, in_ready}, 32'd1);
    chk("out_valid_idle", {31'd0, out_valid}, 32'd0);

    foreach (vecs[i])
      run_word(vecs[i].data, vecs[i].sign, vecs[i].mag, vecs[i].hold, vecs[i].early);

    // in_valid held through the handoff edge must not be accepted on that edge.
    in_valid = 1'b1;
    in_data  = 8'hC8;
    @(posedge clk);
    #1;
    in_data = 8'h12;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("done_before_handoff", {31'd0, out_valid}, 32'd1);
    chk("held_sign_c8", {23'd0, out_sign, out_mag}, {23'd0, 1'b1, 8'h38});
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("no_accept_on_handoff", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("accept_next_cycle", {31'd0, busy}, 32'd1);
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("second_word", {22'd0, out_valid, out_sign, out_mag}, {22'd0, 1'b1, 1'b0, 8'h12});
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset in the middle of SHIFT, cnt=3.
    in_valid = 1'b1;
    in_data  = 8'hB3;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {20'd0, in_ready, out_valid, out_sign, busy, out_mag}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("midrst_no_valid", {31'd0, out_valid}, 32'd0);
    end
    rst_n = 1'b1;
    #1;
    chk("midrst_in_ready_pre", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    chk("midrst_in_ready_post", {31'd0, in_ready}, 32'd1);
    chk("midrst_still_idle", {30'd0, out_valid, busy}, 32'd0);
    run_word(8'h7F, 1'b0, 8'h7F, 0, 1'b0);

    // Randomized traffic against the arithmetic model.
    fork
      begin : driver
        for (int n = 0; n < NRAND; n++) begin
          int w;
          logic [7:0] x;
          repeat ($urandom_range(0, 3)) @(negedge clk);
          x = 8'($urandom);
          in_valid = 1'b1;
          in_data  = x;
          w = 0;
          while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
          end
          if (!in_ready) begin
            chk("rand_accept_timeout", 32'd1, 32'd0);
            break;
          end
          expq.push_back(x);
          @(posedge clk);
          #1;
          in_valid = 1'b0;
          in_data  = 8'($urandom);
        end
      end
      begin : monitor
        int got;
        int cyc;
        got = 0;
        cyc = 0;
        while (got < NRAND && cyc < 60000) begin
          @(negedge clk);
          cyc++;
          out_ready = 1'($urandom_range(0, 1));
          if (out_valid && out_ready) begin
            logic [8:0] e;
            if (expq.size() == 0) begin
              chk("rand_unexpected_result", 32'd1, 32'd0);
            end else begin
              e = model(expq.pop_front());
              chk("rand_result", {23'd0, out_sign, out_mag}, {23'd0, e});
            end
            got++;
          end
        end
        chk("rand_count", got, NRAND);
        out_ready = 1'b0;
      end
    join
    @(negedge clk);
    chk("rand_queue_empty", expq.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
